crc_share_sched: RTL and testbench
==================================

Name: crc_share_sched

Overview:
- Time-shares one 16-bit `Crc` engine (32-bit data input, enable input, 16-bit output, synchronous active-low reset) between NUM_REQ frame requesters, e.g. per-port ingress checkers.
- Round-robin grants one requester per frame and clears the engine before each frame.
- Streams the granted requester's words into the engine, then returns the final CRC tagged with the requester ID.
- Aborts frames that exceed MAX_WORDS.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width IDW = clog2(NUM_REQ), minimum 1
MAX_WORDS, 384, maximum 32-bit words per frame (1536 bytes); the word counter is 16 bits

Ports:
iClk  in  1  clock; all logic on rising edge
iRst_n  in  1  synchronous active-low reset
iReq  in  NUM_REQ  per-requester word valid
iData  in  32*NUM_REQ  per-requester word; requester k uses bits [32k+31:32k]
iLast  in  NUM_REQ  per-requester last-word flag, qualified by iReq
oAck  out  NUM_REQ  word accepted this cycle (combinational)
oCrcData  out  32  to engine iData
oCrcEn  out  1  to engine iCrcEn
oCrcRst_n  out  1  to engine iRst_n
iCrc  in  16  from engine oCrc
oDone  out  1  one-cycle pulse: frame CRC valid
oDoneId  out  IDW  requester of completed/aborted frame
oCrcVal  out  16  final CRC, held until next oDone
oErr  out  1  one-cycle pulse: frame aborted (length overflow)

Behaviour:
- Engine contract (decided): oCrc updates on each edge where iCrcEn=1. The value is stable the cycle after the last enable. Engine reset is synchronous.
- States: IDLE, CLEAR, STREAM, WAIT. Grant register G, word counter C, round-robin pointer P.
- Reset (iRst_n=0):
  - state=IDLE, P=NUM_REQ-1, C=0.
  - oDone=0, oErr=0, oDoneId=0, oCrcVal=0.
  - oCrcRst_n=0, oCrcEn=0, oAck=0.
- oCrcRst_n = iRst_n AND (state != CLEAR).
- IDLE:
  - If any iReq: G = first asserted index searching P+1, P+2, ... mod NUM_REQ; C=0; go to CLEAR.
  - No oAck in IDLE.
- CLEAR: oCrcRst_n=0 for exactly one cycle; oCrcEn=0; go to STREAM.
- STREAM:
  - oCrcData=iData[G], oCrcEn=iReq[G], oAck[G]=iReq[G]; all other oAck bits 0.
  - iReq[G]=0 stalls with no timeout. Other requesters are ignored until the frame ends.
  - On each accepted word C increments.
  - Accepted word with iLast[G]=1: go to WAIT.
  - Accepted word where C+1 == MAX_WORDS and iLast[G]=0: register oErr=1, oDoneId=G, P=G; go to IDLE; oDone stays 0.
  - Remaining words of an aborted requester are treated as a new frame at its next grant.
  - A last word on exactly word MAX_WORDS is legal (no error).
- WAIT (one cycle): register oCrcVal=iCrc, oDoneId=G, oDone=1, P=G; go to IDLE.
- Latency:
  - Request sampled in IDLE at edge E0. CLEAR during E0..E1. Words accepted at E2..E(W+1) with no stalls. WAIT during E(W+1)..E(W+2).
  - oDone is high during cycle E(W+2)..E(W+3).
  - The next grant can be taken at E(W+3): 3 cycles of overhead per frame.
- Simultaneous events: a requester whose frame just ended has lowest priority at the next arbitration. Requests arriving during STREAM/WAIT wait until IDLE.
- iLast on a non-granted requester has no effect. iLast without iReq is ignored.
- Reset mid-frame: immediate return to the reset state; no oDone/oErr. oCrcRst_n is held low during reset.

Test Plan:
- Reset: hold iRst_n=0 for 10 cycles with iReq=4'b1111 → oAck=0, oCrcEn=0, oCrcRst_n=0, oDone=0, oErr=0, oCrcVal=0. Release → first grant is ID 0.
- Single frame:
  - Stimulus: req1 sends 4 words 0x12345678, 0xDEADBEEF, 0x00000000, 0xFFFFFFFF, iLast on word 4, no stalls.
  - Required: one CLEAR cycle with oCrcRst_n=0; oCrcEn high exactly 4 cycles; oDone one cycle, 6 edges after the sampling edge.
  - Required: oDoneId=1; oCrcVal equals a standalone `Crc` fed the same 4 words after reset.
- Round robin: all four iReq held high, each sending 2-word frames → grant order 0,1,2,3,0. Back-to-back oDone pulses 5 cycles apart. No oAck to a non-granted requester.
- Stall: req2 sends 3 words with iReq low for 3 cycles between words 1 and 2 → oCrcEn/oAck low during the gap. Same oCrcVal as the unstalled run; oDone 3 cycles later than unstalled.
- Overflow:
  - Run with MAX_WORDS=8: req3 streams 8 words without iLast → oErr pulses with oDoneId=3, no oDone; next grant goes to another requester if one is pending.
  - Same run, 8 words with iLast on word 8 → oDone, no oErr.
- Reset mid-frame: iRst_n=0 for 1 cycle after word 2 of a 5-word frame → no oDone/oErr. P resets so ID 0 wins. The next frame's CRC matches a fresh-engine reference.

Source files
------------

// File: rtl/crc_share_sched_if.sv
// Bus bundle for crc_share_sched: requester handshake, CRC engine drive and frame result.
// The scheduler takes the slave view; the requesters/engine side takes the master view.
interface crc_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    iReq;
  logic [32*NUM_REQ-1:0] iData;
  logic [NUM_REQ-1:0]    iLast;
  logic [NUM_REQ-1:0]    oAck;
  logic [31:0]           oCrcData;
  logic                  oCrcEn;
  logic                  oCrcRst_n;
  logic [15:0]           iCrc;
  logic                  oDone;
  logic [IDW-1:0]        oDoneId;
  logic [15:0]           oCrcVal;
  logic                  oErr;

  modport slave (
    input  iReq, iData, iLast, iCrc,
    output oAck, oCrcData, oCrcEn, oCrcRst_n, oDone, oDoneId, oCrcVal, oErr
  );

  modport master (
    output iReq, iData, iLast, iCrc,
    input  oAck, oCrcData, oCrcEn, oCrcRst_n, oDone, oDoneId, oCrcVal, oErr
  );
endinterface

// File: rtl/crc_share_sched.sv
// Round-robin time-sharing of one 16-bit CRC engine between NUM_REQ frame requesters.
// Each frame: clear the engine, stream the granted requester's words, report the tagged CRC.
module crc_share_sched #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_WORDS = 384
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  crc_share_sched_if.slave     bus
);
  localparam int              IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0]     MAXW    = 16'(MAX_WORDS);
  localparam logic [IDW-1:0]  PTR_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        crc_val_q, crc_val_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDW-1:0]     pick;
  logic               found;
  logic [NUM_REQ-1:0] ack;
  logic               crc_en;
  logic [31:0]        words [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) words[k] = bus.iData[32*k +: 32];
  end

  // Search starts just after the last serviced requester, so it has lowest priority next.
  always_comb begin
    int cand;
    cand  = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.iReq[IDW'(cand)]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    crc_val_d = crc_val_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ack       = '0;
    crc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = STREAM;
      STREAM: begin
        if (bus.iReq[gnt_q]) begin
          ack[gnt_q] = 1'b1;
          crc_en     = 1'b1;
          cnt_d      = cnt_q + 16'd1;
          if (bus.iLast[gnt_q]) begin
            state_d = WAIT;
          end else if (cnt_q + 16'd1 == MAXW) begin
            // Over-length frame: report and drop; leftover words start a fresh frame later.
            err_d     = 1'b1;
            done_id_d = gnt_q;
            ptr_d     = gnt_q;
            state_d   = IDLE;
          end
        end
      end
      WAIT: begin
        // Engine output settled on the edge that took the last word.
        crc_val_d = bus.iCrc;
        done_id_d = gnt_q;
        done_d    = 1'b1;
        ptr_d     = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      done_id_q <= '0;
      crc_val_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      crc_val_q <= crc_val_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs are forced quiet while reset is asserted, whatever the state.
  assign bus.oAck      = ack & {NUM_REQ{iRst_n}};
  assign bus.oCrcEn    = crc_en & iRst_n;
  assign bus.oCrcRst_n = iRst_n & (state_q != CLEAR);
  assign bus.oCrcData  = words[gnt_q];
  assign bus.oDone     = done_q;
  assign bus.oErr      = err_q;
  assign bus.oDoneId   = done_id_q;
  assign bus.oCrcVal   = crc_val_q;
endmodule

// File: tb/tb_crc_share_sched.sv
// Directed bench for crc_share_sched: requester queues, a behavioural CRC-16 engine,
// and a scoreboard of expected frame results in completion order.
module tb_crc_share_sched;
  localparam int NR   = 4;
  localparam int IDW  = 2;
  localparam int MAXW = 8;

  typedef struct {
    logic [31:0] d;
    bit          last;
    int          gap;
  } word_t;

  typedef struct {
    int          id;
    logic [15:0] crc;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] eng;
  word_t       rq [NR][$];
  exp_t        expq [$];
  int          ev_cycles [$];
  int          cycle = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          ev_cnt = 0;
  int          en_cnt = 0;
  int          rlo_cnt = 0;

  always #5 clk = ~clk;

  crc_share_sched_if #(.NUM_REQ(NR), .IDW(IDW)) bus ();

  crc_share_sched #(.NUM_REQ(NR), .MAX_WORDS(MAXW)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  // CRC-16/CCITT (poly 0x1021, init 0xFFFF), 32-bit word MSB first.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_frame(input logic [31:0] w [$]);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (w[i]) r = crc_word(r, w[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!bus.oCrcRst_n)  eng <= 16'hFFFF;
    else if (bus.oCrcEn) eng <= crc_word(eng, bus.oCrcData);
  end
  assign bus.iCrc = eng;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input int k, input logic [31:0] w [$], input bit lst,
                            input int gap_at, input int gap, input bit want);
    word_t e;
    exp_t  x;
    foreach (w[i]) begin
      e.d    = w[i];
      e.last = lst && (i == w.size() - 1);
      e.gap  = (i == gap_at) ? gap : 0;
      rq[k].push_back(e);
    end
    if (want) begin
      x.id  = k;
      x.crc = crc_frame(w);
      x.err = !lst;
      expq.push_back(x);
    end
  endtask

  task automatic drive();
    logic [NR-1:0]    r;
    logic [NR-1:0]    l;
    logic [32*NR-1:0] d;
    for (int k = 0; k < NR; k++) begin
      if (rq[k].size() > 0 && rq[k][0].gap == 0) begin
        r[k] = 1'b1;
        l[k] = rq[k][0].last;
        d[32*k +: 32] = rq[k][0].d;
      end else begin
        r[k] = 1'b0;
        l[k] = 1'b1;
        d[32*k +: 32] = 32'hBAD0_0000 | 32'(k);
      end
    end
    bus.iReq  = r;
    bus.iLast = l;
    bus.iData = d;
  endtask

  task automatic monitor();
    exp_t x;
    if (bus.oDone || bus.oErr) begin
      ev_cnt++;
      ev_cycles.push_back(cycle);
      if (expq.size() == 0) begin
        chk("unexpected_event", 32'({bus.oDone, bus.oErr}), 0);
      end else begin
        x = expq.pop_front();
        chk("event_kind", 32'({bus.oDone, bus.oErr}), x.err ? 32'd1 : 32'd2);
        chk("done_id", 32'(bus.oDoneId), 32'(x.id));
        if (!x.err) chk("crc_val", 32'(bus.oCrcVal), 32'(x.crc));
      end
    end
  endtask

  task automatic cyc();
    logic [NR-1:0] ack;
    word_t         e;
    drive();
    #1;
    ack = bus.oAck;
    if (bus.oCrcEn)     en_cnt++;
    if (!bus.oCrcRst_n) rlo_cnt++;
    if (ack != '0) begin
      chk("ack_onehot", 32'($onehot(ack)), 1);
      chk("ack_without_req", 32'(ack & ~bus.iReq), 0);
      chk("en_with_ack", 32'(bus.oCrcEn), 1);
    end
    @(posedge clk);
    cycle++;
    for (int k = 0; k < NR; k++) begin
      if (ack[k] && rq[k].size() > 0) e = rq[k].pop_front();
      else if (rq[k].size() > 0 && rq[k][0].gap > 0) rq[k][0].gap = rq[k][0].gap - 1;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_ev(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ev_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(ev_cnt), 32'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [$];
    int          t0;
    int          evb;
    int          n;

    // All four requesters hold 2-word frames through reset; requester 0 has a second frame.
    for (int k = 0; k < NR; k++) begin
      w = {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)};
      push_frame(k, w, 1'b1, -1, 0, 1'b1);
    end
    w = {32'h3000_0000, 32'h4000_0000};
    push_frame(0, w, 1'b1, -1, 0, 1'b1);

    rst_n = 1'b0;
    @(negedge clk);
    repeat (10) cyc();
    chk("rst_ack", 32'(bus.oAck), 0);
    chk("rst_crc_en", 32'(bus.oCrcEn), 0);
    chk("rst_crc_rst_n", 32'(bus.oCrcRst_n), 0);
    chk("rst_done", 32'(bus.oDone), 0);
    chk("rst_err", 32'(bus.oErr), 0);
    chk("rst_crc_val", 32'(bus.oCrcVal), 0);
    chk("rst_done_id", 32'(bus.oDoneId), 0);
    chk("rst_no_events", 32'(ev_cnt), 0);

    rst_n = 1'b1;
    wait_ev(5, 60, "rr_events");
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(ev_cycles[i] - ev_cycles[i-1]), 5);

    repeat (2) cyc();
    w = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF};
    en_cnt  = 0;
    rlo_cnt = 0;
    t0 = cycle + 1;
    push_frame(1, w, 1'b1, -1, 0, 1'b1);
    wait_ev(6, 20, "single_event");
    chk("single_latency", 32'(ev_cycles[$] - t0), 6);
    chk("single_en_cycles", 32'(en_cnt), 4);
    chk("single_clear_cycles", 32'(rlo_cnt), 1);

    cyc();
    w = {32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h1357_9BDF};
    t0 = cycle + 1;
    push_frame(2, w, 1'b1, -1, 0, 1'b1);
    wait_ev(7, 20, "unstalled_event");
    chk("unstalled_latency", 32'(ev_cycles[$] - t0), 5);
    cyc();
    en_cnt = 0;
    t0 = cycle + 1;
    push_frame(2, w, 1'b1, 1, 3, 1'b1);
    wait_ev(8, 30, "stalled_event");
    chk("stalled_latency", 32'(ev_cycles[$] - t0), 8);
    chk("stalled_en_cycles", 32'(en_cnt), 3);

    // Over-length frame from 3, then 0 pending, then 3's leftover words as a new frame.
    cyc();
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'hA5A5_0000 + 32'(i));
    push_frame(3, w, 1'b0, -1, 0, 1'b1);
    w = {32'h00C0_FFEE};
    push_frame(0, w, 1'b1, -1, 0, 1'b1);
    w = {32'h3333_0001, 32'h3333_0002};
    push_frame(3, w, 1'b1, -1, 0, 1'b1);
    wait_ev(11, 60, "overflow_events");

    cyc();
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'h5A5A_0000 + 32'(i));
    push_frame(3, w, 1'b1, -1, 0, 1'b1);
    wait_ev(12, 30, "max_len_event");

    // Leave the pointer at 0 so a non-reset arbiter would pick 1 then 2.
    cyc();
    w = {32'h0F0F_0F0F};
    push_frame(0, w, 1'b1, -1, 0, 1'b1);
    wait_ev(13, 20, "pre_reset_event");
    cyc();
    w = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    push_frame(1, w, 1'b1, -1, 0, 1'b0);
    w = {32'h0A0A_0001, 32'h0A0A_0002};
    push_frame(0, w, 1'b1, -1, 0, 1'b1);
    w = {32'h0C0C_0001};
    push_frame(2, w, 1'b1, -1, 0, 1'b1);
    n = 0;
    while (rq[1].size() > 3 && n < 20) begin
      cyc();
      n++;
    end
    chk("midframe_words_taken", 32'(rq[1].size()), 3);
    evb = ev_cnt;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rq[1].delete();
    chk("no_event_on_reset", 32'(ev_cnt), 32'(evb));
    wait_ev(evb + 2, 40, "post_reset_events");

    repeat (3) cyc();
    chk("scoreboard_empty", 32'(expq.size()), 0);
    chk("event_total", 32'(ev_cnt), 32'(evb + 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
